ring_osc_ctrl: RTL and testbench



---
 rtl/ring_osc_ctrl.sv | 138 +++++++++++++
 tb/tb_ring_osc_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ring_osc_ctrl.sv
// Ring oscillator sequencing (park/init/run) and gated rising-edge counter.
// Optional macro ROC_STUCK_DET_EN adds the STUCK dead-oscillator flag.
module ring_osc_ctrl #(
  parameter int CNT_W  = 16,
  parameter int GATE_W = 12,
  parameter int SETTLE = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  input  logic [GATE_W-1:0] GATE_LEN,
  input  logic              RO_IN,
  output logic              RO_A1,
  output logic              RO_A2,
  output logic              BUSY,
  output logic              DONE,
  output logic [CNT_W-1:0]  COUNT,
  output logic              OVF
`ifdef ROC_STUCK_DET_EN
  ,
  output logic              STUCK
`endif
);

  localparam int SW = $clog2(SETTLE + 1);
  localparam int TW = (GATE_W > SW) ? GATE_W : SW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_RUN,
    S_STOP,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_nxt;
  logic [TW-1:0]     r_tmr;
  logic [TW-1:0]     w_tmr_nxt;
  logic [GATE_W-1:0] r_gate;
  logic              r_s1, r_s2, r_s3;
  logic              w_strobe;
  logic              w_accept;
  logic              w_a1, w_a2, w_busy, w_done;

  assign w_strobe = r_s2 & ~r_s3;
  assign w_accept = (r_state == S_IDLE) && START;

  always_comb begin
    w_nxt     = r_state;
    w_tmr_nxt = r_tmr;
    case (r_state)
      S_IDLE: if (START) w_nxt = S_INIT;
      S_INIT: if (r_tmr == '0) w_nxt = S_RUN;
      S_RUN:  if (r_tmr == '0) w_nxt = S_STOP;
      S_STOP: if (r_tmr == '0) w_nxt = S_DONE;
      S_DONE: w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
    // Timer holds "cycles remaining minus one" for the state being entered.
    if (w_nxt != r_state) begin
      case (w_nxt)
        S_INIT:  w_tmr_nxt = TW'(SETTLE - 1);
        S_RUN:   w_tmr_nxt = TW'(r_gate) - TW'(1);
        S_STOP:  w_tmr_nxt = TW'(1);
        default: w_tmr_nxt = '0;
      endcase
    end else if (r_tmr != '0) begin
      w_tmr_nxt = r_tmr - TW'(1);
    end
  end

  always_comb begin
    w_a1   = (w_nxt == S_INIT) || (w_nxt == S_RUN);
    w_a2   = (w_nxt == S_RUN);
    w_busy = (w_nxt == S_INIT) || (w_nxt == S_RUN) || (w_nxt == S_STOP);
    w_done = (w_nxt == S_DONE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
      r_tmr   <= '0;
      r_gate  <= '0;
      RO_A1   <= 1'b0;
      RO_A2   <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_tmr   <= w_tmr_nxt;
      RO_A1   <= w_a1;
      RO_A2   <= w_a2;
      BUSY    <= w_busy;
      DONE    <= w_done;
      if (w_accept) r_gate <= (GATE_LEN == '0) ? GATE_W'(1) : GATE_LEN;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= RO_IN;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      COUNT <= '0;
      OVF   <= 1'b0;
    end else if (w_accept) begin
      COUNT <= '0;
      OVF   <= 1'b0;
    end else if ((r_state == S_RUN) && w_strobe) begin
      if (COUNT == '1) OVF <= 1'b1;
      else             COUNT <= COUNT + CNT_W'(1);
    end
  end

`ifdef ROC_STUCK_DET_EN
  // COUNT is frozen through STOP, so testing it on STOP exit equals RUN exit.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      STUCK <= 1'b0;
    end else if (w_accept) begin
      STUCK <= 1'b0;
    end else if ((r_state == S_STOP) && (w_nxt == S_DONE)) begin
      STUCK <= (COUNT == '0);
    end
  end
`endif

endmodule

// File: tb/tb_ring_osc_ctrl.sv
// Randomized self-checking bench for ring_osc_ctrl with an oscillator model
// driven by the DUT's A1/A2; STUCK checks build when ROC_STUCK_DET_EN is set.
module tb_ring_osc_ctrl;

  localparam int S = 4;

  logic        clk, rst_n, start;
  logic [11:0] gate_len;
  logic        ro_in, ro_in4;
  logic        a1, a2, busy, done, ovf;
  logic [15:0] count;
  logic        a1_4, a2_4, busy4, done4, ovf4;
  logic [3:0]  count4;
`ifdef ROC_STUCK_DET_EN
  logic        stuck, stuck4;
  logic        m_stuck0, m_stuck_done;
`endif

  int tests  = 0;
  int failed = 0;

  ring_osc_ctrl #(.CNT_W(16), .GATE_W(12), .SETTLE(S)) dut (
    .CLK(clk), .RST_N(rst_n), .START(start), .GATE_LEN(gate_len), .RO_IN(ro_in),
    .RO_A1(a1), .RO_A2(a2), .BUSY(busy), .DONE(done), .COUNT(count), .OVF(ovf)
`ifdef ROC_STUCK_DET_EN
    , .STUCK(stuck)
`endif
  );

  ring_osc_ctrl #(.CNT_W(4), .GATE_W(12), .SETTLE(S)) dut4 (
    .CLK(clk), .RST_N(rst_n), .START(start), .GATE_LEN(gate_len), .RO_IN(ro_in4),
    .RO_A1(a1_4), .RO_A2(a2_4), .BUSY(busy4), .DONE(done4), .COUNT(count4), .OVF(ovf4)
`ifdef ROC_STUCK_DET_EN
    , .STUCK(stuck4)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Oscillator model: quiet unless A=11, first rise osc_h cycles after RUN entry.
  int osc_h    = 4;
  bit osc_dead = 1'b0;
  int n0 = 0, n1 = 0;
  always @(posedge clk) begin
    #1;
    if (a1 && a2 && !osc_dead) begin ro_in = ((n0 / osc_h) % 2) == 1; n0++; end
    else begin ro_in = 1'b0; n0 = 0; end
    if (a1_4 && a2_4 && !osc_dead) begin ro_in4 = ((n1 / osc_h) % 2) == 1; n1++; end
    else begin ro_in4 = 1'b0; n1 = 0; end
  end

  // Rises happen at odd multiples of h after RUN entry; each is counted if its
  // strobe (3 edges after the rise) still lands inside the G-cycle window.
  function automatic int exp_edges(int ge, int h);
    if (ge - 3 < h) return 0;
    return ((ge - 3) / h + 1) / 2;
  endfunction

  int          m_done_cnt, m_done_j, m_seq_bad, m_bad_j, m_ovf, m_ovf4;
  int          m_count, m_count4, m_hold;

  // Entered at a negedge with the DUT idle; returns at a negedge with it idle.
  task automatic measure(input int g, input bit hold, input bit poke);
    int ge, last;
    logic [1:0] ea;
    logic eb, ed;
    ge = (g == 0) ? 1 : g;
    last = S + ge + 3;
    m_done_cnt = 0; m_done_j = -1; m_seq_bad = 0; m_bad_j = -1;
    m_count = -1; m_count4 = -1; m_ovf = -1; m_ovf4 = -1;
    start = 1'b1;
    gate_len = 12'(g);
    @(posedge clk);
    for (int j = 0; j <= last; j++) begin
      @(negedge clk);
      ea = (j < S) ? 2'b10 : (j < S + ge) ? 2'b11 : 2'b00;
      eb = (j < S + ge + 2);
      ed = (j == S + ge + 2);
      if ({a1, a2} !== ea || {a1_4, a2_4} !== ea || busy !== eb || done !== ed) begin
        m_seq_bad++;
        if (m_bad_j < 0) m_bad_j = j;
      end
      if (done === 1'b1) begin
        m_done_cnt++; m_done_j = j;
        m_count = count; m_ovf = ovf; m_count4 = count4; m_ovf4 = ovf4;
`ifdef ROC_STUCK_DET_EN
        m_stuck_done = stuck;
`endif
      end
`ifdef ROC_STUCK_DET_EN
      if (j == 0) m_stuck0 = stuck;
`endif
      if (j == last) m_hold = count;
      gate_len = 12'($urandom);
      if (!hold) start = poke && (j == S + 2 || j == S + 9 || j == S + 20);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; gate_len = '0;
    #3;
    tests++;
    if ({a1, a2, busy, done, ovf} !== 5'b0 || count !== 16'd0) begin
      failed++;
      $display("FAIL reset_values: got a=%b%b busy=%b done=%b ovf=%b count=%0d expected all 0",
               a1, a2, busy, done, ovf, count);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({a1, a2, busy, done, ovf} !== 5'b0 || count !== 16'd0) begin
      failed++;
      $display("FAIL idle_after_reset: got a=%b%b busy=%b done=%b count=%0d expected all 0",
               a1, a2, busy, done, count);
    end
  endtask

  task automatic test_basic_count;
    osc_h = 4;
    measure(64, 1'b0, 1'b0);
    tests++;
    if (m_seq_bad !== 0) begin failed++; $display("FAIL basic_seq: %0d bad cycles, first j=%0d expected 0", m_seq_bad, m_bad_j); end
    tests++;
    if (m_done_cnt !== 1 || m_done_j !== 70) begin
      failed++; $display("FAIL basic_done: got %0d pulses at j=%0d expected 1 at j=70", m_done_cnt, m_done_j);
    end
    tests++;
    if (m_count !== 8 || m_ovf !== 0) begin failed++; $display("FAIL basic_count: got %0d ovf=%0d expected 8 ovf=0", m_count, m_ovf); end
    tests++;
    if (m_hold !== 8) begin failed++; $display("FAIL basic_hold: got %0d expected 8", m_hold); end
  endtask

  task automatic test_saturation;
    osc_h = 4;
    measure(200, 1'b0, 1'b0);
    tests++;
    if (m_count4 !== 15 || m_ovf4 !== 1) begin failed++; $display("FAIL sat_count4: got %0d ovf=%0d expected 15 ovf=1", m_count4, m_ovf4); end
    tests++;
    if (m_count !== 25 || m_ovf !== 0) begin failed++; $display("FAIL sat_count16: got %0d ovf=%0d expected 25 ovf=0", m_count, m_ovf); end
    tests++;
    if (m_seq_bad !== 0) begin failed++; $display("FAIL sat_seq: %0d bad cycles, first j=%0d expected 0", m_seq_bad, m_bad_j); end
  endtask

  task automatic test_ignored_start;
    osc_h = 4;
    measure(64, 1'b0, 1'b1);
    tests++;
    if (m_done_cnt !== 1 || m_seq_bad !== 0) begin
      failed++; $display("FAIL ignored_start: got %0d done, %0d bad cycles expected 1 done, 0 bad", m_done_cnt, m_seq_bad);
    end
    tests++;
    if (m_count !== 8) begin failed++; $display("FAIL ignored_count: got %0d expected 8", m_count); end
  endtask

  task automatic test_gate_zero;
    osc_h = 4;
    measure(0, 1'b0, 1'b0);
    tests++;
    if (m_done_j !== S + 3 || m_seq_bad !== 0) begin
      failed++; $display("FAIL gate0_timing: got done j=%0d bad=%0d expected j=%0d bad=0", m_done_j, m_seq_bad, S + 3);
    end
    tests++;
    if (m_count !== 0 || m_ovf4 !== 0) begin failed++; $display("FAIL gate0_count: got %0d ovf4=%0d expected 0 0", m_count, m_ovf4); end
  endtask

  task automatic test_back_to_back;
    int c1, e;
    osc_h = 4;
    e = exp_edges(40, 4);
    measure(40, 1'b1, 1'b0);
    c1 = m_count;
    tests++;
    if (c1 !== e || m_seq_bad !== 0) begin failed++; $display("FAIL b2b_first: got %0d bad=%0d expected %0d bad=0", c1, m_seq_bad, e); end
    measure(40, 1'b0, 1'b0);
    tests++;
    if (m_count !== c1 || m_count !== e || m_seq_bad !== 0) begin
      failed++; $display("FAIL b2b_second: got %0d bad=%0d expected %0d bad=0", m_count, m_seq_bad, e);
    end
  endtask

  task automatic test_random;
    int g, ge, e;
    for (int i = 0; i < 6; i++) begin
      g = $urandom_range(0, 90);
      osc_h = $urandom_range(2, 6);
      ge = (g == 0) ? 1 : g;
      e = exp_edges(ge, osc_h);
      measure(g, 1'b0, 1'b0);
      tests++;
      if (m_count !== e || m_done_j !== S + ge + 2 || m_seq_bad !== 0) begin
        failed++; $display("FAIL rand_g%0d_h%0d: got count=%0d j=%0d bad=%0d expected %0d j=%0d bad=0",
                           g, osc_h, m_count, m_done_j, m_seq_bad, e, S + ge + 2);
      end
      tests++;
      if (m_count4 !== ((e > 15) ? 15 : e) || m_ovf4 !== ((e > 15) ? 1 : 0)) begin
        failed++; $display("FAIL rand_sat_g%0d_h%0d: got %0d ovf=%0d expected %0d", g, osc_h, m_count4, m_ovf4, e);
      end
    end
  endtask

  task automatic test_async_reset;
    int dones;
    osc_h = 4;
    start = 1'b1; gate_len = 12'd64;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (S + 10) @(negedge clk);
    tests++;
    if ({a1, a2} !== 2'b11) begin failed++; $display("FAIL pre_reset_run: got a=%b%b expected 11", a1, a2); end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({a1, a2, busy, done} !== 4'b0 || count !== 16'd0) begin
      failed++; $display("FAIL async_reset: got a=%b%b busy=%b done=%b count=%0d expected 0", a1, a2, busy, done, count);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int j = 0; j < 90; j++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    tests++;
    if (dones !== 0) begin failed++; $display("FAIL reset_no_done: got %0d busy/done cycles expected 0", dones); end
  endtask

`ifdef ROC_STUCK_DET_EN
  task automatic test_stuck;
    osc_h = 4; osc_dead = 1'b1;
    measure(64, 1'b0, 1'b0);
    tests++;
    if (m_count !== 0 || m_stuck_done !== 1'b1) begin
      failed++; $display("FAIL stuck_set: got count=%0d stuck=%b expected 0 1", m_count, m_stuck_done);
    end
    osc_dead = 1'b0;
    measure(64, 1'b0, 1'b0);
    tests++;
    if (m_stuck0 !== 1'b0 || m_stuck_done !== 1'b0 || m_count !== 8) begin
      failed++; $display("FAIL stuck_clear: got stuck0=%b stuck=%b count=%0d expected 0 0 8", m_stuck0, m_stuck_done, m_count);
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    ro_in = 1'b0; ro_in4 = 1'b0;
    test_reset();
    test_basic_count();
    test_saturation();
    test_ignored_start();
    test_gate_zero();
    test_back_to_back();
    test_random();
    test_async_reset();
`ifdef ROC_STUCK_DET_EN
    test_stuck();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
